// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order commit buffer with tag writeback and branch flush
//
// Purpose: allocates one tag per issued instruction, captures ALU/LSB result
// broadcasts by tag, and retires entries in program order. A mispredicted
// branch at the head flushes every entry.
//
// Ports:
//   clockIn, resetIn (async, active-low), readyIn (global enable)
//   issue*            allocation request at tail; issueTag/full report tail state
//   alu*/lsb*         result broadcasts, matched against busy entries by tag
//   queryTag*/query*  combinational operand lookup (broadcast bypass first)
//   commit*           registered REG / STORE retirement pulses
//   flushFlag/flushPc registered misprediction redirect pulse
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 issueFlag,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueRd,
    input  logic                 issueReady,
    input  logic [31:0]          issueVal,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    output logic [ROB_WIDTH-1:0] issueTag,
    output logic                 full,
    input  logic                 aluFlag,
    input  logic [31:0]          aluVal,
    input  logic [ROB_WIDTH-1:0] aluDest,
    input  logic                 lsbFlag,
    input  logic [31:0]          lsbVal,
    input  logic [ROB_WIDTH-1:0] lsbDest,
    input  logic [ROB_WIDTH-1:0] queryTagJ,
    input  logic [ROB_WIDTH-1:0] queryTagK,
    output logic                 queryReadyJ,
    output logic                 queryReadyK,
    output logic [31:0]          queryValJ,
    output logic [31:0]          queryValK,
    output logic                 commitFlag,
    output logic [4:0]           commitRd,
    output logic [31:0]          commitVal,
    output logic [ROB_WIDTH-1:0] commitTag,
    output logic                 commitStoreFlag,
    output logic [ROB_WIDTH-1:0] commitStoreTag,
    output logic                 flushFlag,
    output logic [31:0]          flushPc
);

    localparam int ROB_SIZE = 2 ** ROB_WIDTH;

    localparam logic [1:0]           TYPE_STORE  = 2'd1;
    localparam logic [1:0]           TYPE_BRANCH = 2'd2;
    localparam logic [ROB_WIDTH-1:0] PTR_ONE     = 1;
    localparam logic [ROB_WIDTH:0]   CNT_ONE     = 1;
    localparam logic [ROB_WIDTH:0]   CNT_FULL    = {1'b1, {ROB_WIDTH{1'b0}}};

    logic        busy_q  [ROB_SIZE];
    logic        ready_q [ROB_SIZE];
    logic [1:0]  type_q  [ROB_SIZE];
    logic [4:0]  rd_q    [ROB_SIZE];
    logic [31:0] val_q   [ROB_SIZE];
    logic        pred_q  [ROB_SIZE];
    logic [31:0] altpc_q [ROB_SIZE];

    logic [ROB_WIDTH-1:0] head_q;
    logic [ROB_WIDTH-1:0] tail_q;
    logic [ROB_WIDTH:0]   count_q;
    logic [ROB_WIDTH:0]   count_d;

    logic issue_ok;
    logic head_fire;
    logic mispredict;

    assign full     = (count_q == CNT_FULL);
    assign issueTag = tail_q;
    assign issue_ok = issueFlag && !full;

    // Commit looks only at the registered ready bit, so a result written this
    // cycle retires on the following cycle at the earliest.
    assign head_fire  = busy_q[head_q] && ready_q[head_q];
    assign mispredict = head_fire && (type_q[head_q] == TYPE_BRANCH) &&
                        (val_q[head_q][0] != pred_q[head_q]);

    always_comb begin
        count_d = count_q;
        if (issue_ok && !head_fire) begin
            count_d = count_q + CNT_ONE;
        end else if (!issue_ok && head_fire) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Operand lookup: live broadcasts take precedence over stored results.
    always_comb begin
        queryReadyJ = 1'b0;
        queryValJ   = '0;
        if (aluFlag && aluDest == queryTagJ) begin
            queryReadyJ = 1'b1;
            queryValJ   = aluVal;
        end else if (lsbFlag && lsbDest == queryTagJ) begin
            queryReadyJ = 1'b1;
            queryValJ   = lsbVal;
        end else if (ready_q[queryTagJ]) begin
            queryReadyJ = 1'b1;
            queryValJ   = val_q[queryTagJ];
        end
    end

    always_comb begin
        queryReadyK = 1'b0;
        queryValK   = '0;
        if (aluFlag && aluDest == queryTagK) begin
            queryReadyK = 1'b1;
            queryValK   = aluVal;
        end else if (lsbFlag && lsbDest == queryTagK) begin
            queryReadyK = 1'b1;
            queryValK   = lsbVal;
        end else if (ready_q[queryTagK]) begin
            queryReadyK = 1'b1;
            queryValK   = val_q[queryTagK];
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commitFlag      <= 1'b0;
            commitRd        <= '0;
            commitVal       <= '0;
            commitTag       <= '0;
            commitStoreFlag <= 1'b0;
            commitStoreTag  <= '0;
            flushFlag       <= 1'b0;
            flushPc         <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
                type_q[i]  <= '0;
                rd_q[i]    <= '0;
                val_q[i]   <= '0;
                pred_q[i]  <= 1'b0;
                altpc_q[i] <= '0;
            end
        end else if (!readyIn) begin
            commitFlag      <= 1'b0;
            commitRd        <= '0;
            commitVal       <= '0;
            commitTag       <= '0;
            commitStoreFlag <= 1'b0;
            commitStoreTag  <= '0;
            flushFlag       <= 1'b0;
            flushPc         <= '0;
        end else begin
            commitFlag      <= 1'b0;
            commitRd        <= '0;
            commitVal       <= '0;
            commitTag       <= '0;
            commitStoreFlag <= 1'b0;
            commitStoreTag  <= '0;
            flushFlag       <= 1'b0;
            flushPc         <= '0;

            if (mispredict) begin
                // Everything behind the branch is wrong-path; issue and
                // writeback arriving this cycle are dropped with it.
                flushFlag <= 1'b1;
                flushPc   <= altpc_q[head_q];
                head_q    <= '0;
                tail_q    <= '0;
                count_q   <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy_q[i]  <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
            end else begin
                // LSB first so a same-tag ALU write overrides it.
                if (lsbFlag && busy_q[lsbDest]) begin
                    ready_q[lsbDest] <= 1'b1;
                    val_q[lsbDest]   <= lsbVal;
                end
                if (aluFlag && busy_q[aluDest]) begin
                    ready_q[aluDest] <= 1'b1;
                    val_q[aluDest]   <= aluVal;
                end

                if (issue_ok) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= issueReady;
                    type_q[tail_q]  <= issueType;
                    rd_q[tail_q]    <= issueRd;
                    val_q[tail_q]   <= issueVal;
                    pred_q[tail_q]  <= issuePredTaken;
                    altpc_q[tail_q] <= issueAltPc;
                    tail_q          <= tail_q + PTR_ONE;
                end

                if (head_fire) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + PTR_ONE;
                    if (type_q[head_q] == TYPE_STORE) begin
                        commitStoreFlag <= 1'b1;
                        commitStoreTag  <= head_q;
                    end else if (type_q[head_q] != TYPE_BRANCH) begin
                        commitFlag <= 1'b1;
                        commitRd   <= rd_q[head_q];
                        commitVal  <= val_q[head_q];
                        commitTag  <= head_q;
                    end
                end

                count_q <= count_d;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

    logic        clockIn;
    logic        resetIn;
    logic        readyIn;
    logic        issueFlag;
    logic [1:0]  issueType;
    logic [4:0]  issueRd;
    logic        issueReady;
    logic [31:0] issueVal;
    logic        issuePredTaken;
    logic [31:0] issueAltPc;
    logic [3:0]  issueTag;
    logic        full;
    logic        aluFlag;
    logic [31:0] aluVal;
    logic [3:0]  aluDest;
    logic        lsbFlag;
    logic [31:0] lsbVal;
    logic [3:0]  lsbDest;
    logic [3:0]  queryTagJ;
    logic [3:0]  queryTagK;
    logic        queryReadyJ;
    logic        queryReadyK;
    logic [31:0] queryValJ;
    logic [31:0] queryValK;
    logic        commitFlag;
    logic [4:0]  commitRd;
    logic [31:0] commitVal;
    logic [3:0]  commitTag;
    logic        commitStoreFlag;
    logic [3:0]  commitStoreTag;
    logic        flushFlag;
    logic [31:0] flushPc;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
        .issueFlag(issueFlag), .issueType(issueType), .issueRd(issueRd),
        .issueReady(issueReady), .issueVal(issueVal),
        .issuePredTaken(issuePredTaken), .issueAltPc(issueAltPc),
        .issueTag(issueTag), .full(full),
        .aluFlag(aluFlag), .aluVal(aluVal), .aluDest(aluDest),
        .lsbFlag(lsbFlag), .lsbVal(lsbVal), .lsbDest(lsbDest),
        .queryTagJ(queryTagJ), .queryTagK(queryTagK),
        .queryReadyJ(queryReadyJ), .queryReadyK(queryReadyK),
        .queryValJ(queryValJ), .queryValK(queryValK),
        .commitFlag(commitFlag), .commitRd(commitRd), .commitVal(commitVal),
        .commitTag(commitTag), .commitStoreFlag(commitStoreFlag),
        .commitStoreTag(commitStoreTag), .flushFlag(flushFlag), .flushPc(flushPc)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic do_reset();
        resetIn   = 1'b0;
        issueFlag = 1'b0;
        aluFlag   = 1'b0;
        lsbFlag   = 1'b0;
        tick();
        resetIn   = 1'b1;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                             input logic [31:0] v, input logic pt, input logic [31:0] pc);
        issueFlag      = 1'b1;
        issueType      = t;
        issueRd        = rd;
        issueReady     = rdy;
        issueVal       = v;
        issuePredTaken = pt;
        issueAltPc     = pc;
    endtask

    initial begin
        resetIn = 1'b0; readyIn = 1'b1;
        issueFlag = 1'b0; issueType = '0; issueRd = '0; issueReady = 1'b0;
        issueVal = '0; issuePredTaken = 1'b0; issueAltPc = '0;
        aluFlag = 1'b0; aluVal = '0; aluDest = '0;
        lsbFlag = 1'b0; lsbVal = '0; lsbDest = '0;
        queryTagJ = '0; queryTagK = '0;

        // Reset state
        #12;
        check("rst_issueTag", 32'(issueTag), 0);
        check("rst_full", 32'(full), 0);
        check("rst_commitFlag", 32'(commitFlag), 0);
        check("rst_storeFlag", 32'(commitStoreFlag), 0);
        check("rst_flushFlag", 32'(flushFlag), 0);
        check("rst_queryReadyJ", 32'(queryReadyJ), 0);
        check("rst_queryValJ", queryValJ, 0);
        resetIn = 1'b1;
        tick();

        // Basic REG issue, ALU writeback, commit
        set_issue(2'd0, 5'd5, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        issueFlag = 1'b0;
        check("t1_issueTag", 32'(issueTag), 1);
        aluFlag = 1'b1; aluDest = 4'd0; aluVal = 32'h1234; queryTagJ = 4'd0;
        #1;
        check("t1_bypassReady", 32'(queryReadyJ), 1);
        check("t1_bypassVal", queryValJ, 32'h1234);
        tick();
        aluFlag = 1'b0;
        check("t1_noEarlyCommit", 32'(commitFlag), 0);
        tick();
        check("t1_commitFlag", 32'(commitFlag), 1);
        check("t1_commitRd", 32'(commitRd), 5);
        check("t1_commitVal", commitVal, 32'h1234);
        check("t1_commitTag", 32'(commitTag), 0);
        tick();
        check("t1_pulseEnds", 32'(commitFlag), 0);
        check("t1_notFull", 32'(full), 0);

        // Fill to 16, reject 17th, wrap, full-with-commit rejection
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(2'd0, 5'(i), 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        check("t2_full", 32'(full), 1);
        check("t2_tagWrap", 32'(issueTag), 0);
        tick();
        check("t2_17thFull", 32'(full), 1);
        check("t2_17thTag", 32'(issueTag), 0);
        issueFlag = 1'b0;
        aluFlag = 1'b1; aluDest = 4'd0; aluVal = 32'hAA;
        tick();
        aluFlag = 1'b0;
        tick();
        check("t2_commitFlag", 32'(commitFlag), 1);
        check("t2_commitTag", 32'(commitTag), 0);
        check("t2_commitVal", commitVal, 32'hAA);
        check("t2_notFull", 32'(full), 0);
        check("t2_nextTag", 32'(issueTag), 0);
        set_issue(2'd0, 5'd20, 1'b0, 32'h0, 1'b0, 32'h0);
        aluFlag = 1'b1; aluDest = 4'd1; aluVal = 32'h11;
        tick();
        aluFlag = 1'b0;
        check("t2_refullTag", 32'(issueTag), 1);
        check("t2_refull", 32'(full), 1);
        tick();
        issueFlag = 1'b0;
        check("t2_fullCommit", 32'(commitFlag), 1);
        check("t2_fullCommitTag", 32'(commitTag), 1);
        check("t2_fullIssueRejected", 32'(issueTag), 1);
        check("t2_fullAfter", 32'(full), 0);
        queryTagJ = 4'd0;
        #1;
        check("t2_reissuedNotReady", 32'(queryReadyJ), 0);

        // Out-of-order writeback, in-order commit
        do_reset();
        set_issue(2'd0, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        set_issue(2'd0, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        issueFlag = 1'b0;
        aluFlag = 1'b1; aluDest = 4'd1; aluVal = 32'h22;
        tick();
        check("t3_noCommitYoung", 32'(commitFlag), 0);
        aluDest = 4'd0; aluVal = 32'h11;
        tick();
        aluFlag = 1'b0;
        check("t3_noCommitYet", 32'(commitFlag), 0);
        tick();
        check("t3_c0Flag", 32'(commitFlag), 1);
        check("t3_c0Tag", 32'(commitTag), 0);
        check("t3_c0Rd", 32'(commitRd), 3);
        check("t3_c0Val", commitVal, 32'h11);
        tick();
        check("t3_c1Flag", 32'(commitFlag), 1);
        check("t3_c1Tag", 32'(commitTag), 1);
        check("t3_c1Val", commitVal, 32'h22);
        tick();
        check("t3_done", 32'(commitFlag), 0);

        // Dual-port writeback and query bypass
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(2'd0, 5'd1, 1'b0, 32'h0, 1'b0, 32'h0);
            tick();
        end
        issueFlag = 1'b0;
        aluFlag = 1'b1; aluDest = 4'd2; aluVal = 32'd7;
        lsbFlag = 1'b1; lsbDest = 4'd3; lsbVal = 32'd9;
        queryTagJ = 4'd2; queryTagK = 4'd3;
        #1;
        check("t4_qReadyJ", 32'(queryReadyJ), 1);
        check("t4_qValJ", queryValJ, 7);
        check("t4_qReadyK", 32'(queryReadyK), 1);
        check("t4_qValK", queryValK, 9);
        tick();
        aluFlag = 1'b0; lsbFlag = 1'b0;
        #1;
        check("t4_storedJ", queryValJ, 7);
        check("t4_storedK", queryValK, 9);
        check("t4_storedReadyK", 32'(queryReadyK), 1);
        queryTagJ = 4'd0;
        #1;
        check("t4_tag0NotReady", 32'(queryReadyJ), 0);
        check("t4_tag0Val", queryValJ, 0);
        aluFlag = 1'b1; aluDest = 4'd1; aluVal = 32'd5;
        lsbFlag = 1'b1; lsbDest = 4'd1; lsbVal = 32'd6;
        queryTagJ = 4'd1;
        #1;
        check("t4_bypassAluWins", queryValJ, 5);
        tick();
        aluFlag = 1'b0; lsbFlag = 1'b0;
        #1;
        check("t4_storedAluWins", queryValJ, 5);
        check("t4_noCommit", 32'(commitFlag), 0);

        // Store retirement
        do_reset();
        set_issue(2'd1, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0);
        tick();
        issueFlag = 1'b0;
        tick();
        check("t5_storeFlag", 32'(commitStoreFlag), 1);
        check("t5_storeTag", 32'(commitStoreTag), 0);
        check("t5_storeNoReg", 32'(commitFlag), 0);

        // Misprediction flush
        do_reset();
        set_issue(2'd2, 5'd0, 1'b0, 32'h0, 1'b0, 32'h80);
        tick();
        set_issue(2'd0, 5'd7, 1'b1, 32'h70, 1'b0, 32'h0);
        tick();
        set_issue(2'd0, 5'd8, 1'b1, 32'h71, 1'b0, 32'h0);
        tick();
        issueFlag = 1'b0;
        aluFlag = 1'b1; aluDest = 4'd0; aluVal = 32'd1;
        tick();
        aluFlag = 1'b0;
        set_issue(2'd0, 5'd9, 1'b1, 32'h72, 1'b0, 32'h0);
        tick();
        issueFlag = 1'b0;
        check("t6_flushFlag", 32'(flushFlag), 1);
        check("t6_flushPc", flushPc, 32'h80);
        check("t6_flushTag", 32'(issueTag), 0);
        check("t6_flushFull", 32'(full), 0);
        check("t6_flushNoCommit", 32'(commitFlag), 0);
        tick();
        check("t6_flushPulseEnds", 32'(flushFlag), 0);
        for (int i = 0; i < 3; i++) begin
            check("t6_noStaleCommit", 32'(commitFlag), 0);
            tick();
        end
        set_issue(2'd2, 5'd0, 1'b1, 32'd1, 1'b1, 32'h90);
        tick();
        issueFlag = 1'b0;
        tick();
        check("t6_goodBranchNoFlush", 32'(flushFlag), 0);
        check("t6_goodBranchNoCommit", 32'(commitFlag), 0);
        check("t6_goodBranchTag", 32'(issueTag), 1);

        // Enable hold and asynchronous reset mid-operation
        do_reset();
        set_issue(2'd0, 5'd1, 1'b1, 32'hA0, 1'b0, 32'h0);
        tick();
        set_issue(2'd0, 5'd2, 1'b1, 32'hB0, 1'b0, 32'h0);
        tick();
        set_issue(2'd0, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check("t7_commit1", 32'(commitFlag), 1);
        check("t7_commit1Tag", 32'(commitTag), 1);
        check("t7_commit1Val", commitVal, 32'hB0);
        readyIn = 1'b0;
        tick();
        check("t7_holdPulseDrop", 32'(commitFlag), 0);
        check("t7_holdTag", 32'(issueTag), 3);
        readyIn = 1'b1;
        set_issue(2'd0, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0);
        aluFlag = 1'b1; aluDest = 4'd2; aluVal = 32'h55;
        tick();
        issueFlag = 1'b0; aluFlag = 1'b0;
        check("t7_issueTag4", 32'(issueTag), 4);
        check("t7_noCommitYet", 32'(commitFlag), 0);
        tick();
        check("t7_commit2", 32'(commitFlag), 1);
        check("t7_commit2Val", commitVal, 32'h55);
        readyIn = 1'b0;
        #2;
        resetIn = 1'b0;
        #1;
        check("t7_asyncCommitFlag", 32'(commitFlag), 0);
        check("t7_asyncCommitTag", 32'(commitTag), 0);
        check("t7_asyncTag", 32'(issueTag), 0);
        check("t7_asyncFull", 32'(full), 0);
        tick();
        resetIn = 1'b1;
        readyIn = 1'b1;
        aluFlag = 1'b1; aluDest = 4'd3; aluVal = 32'h77;
        tick();
        aluFlag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t7_noStaleCommit", 32'(commitFlag), 0);
            tick();
        end
        check("t7_finalTag", 32'(issueTag), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
